// File: rtl/scale_fifo_rd_arbiter.sv
// Round-robin burst arbiter draining N_SRC show-ahead FIFOs into one stream; optional stall abort via SCALE_ARB_TIMEOUT_EN.
// Latency: grant registered one cycle after a request is seen in IDLE; burst datapath is zero-latency.
// Backpressure: out_rdy drives the granted rd_en directly, so a stalled downstream leaves the word in its FIFO.
module scale_fifo_rd_arbiter #(
  parameter int N_SRC   = 4,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 2,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    arb_en,
  input  logic [LEN_W-1:0]        burst_len,
  input  logic [N_SRC-1:0]        src_vld,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_en,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    busy,
  output logic                    burst_done
`ifdef SCALE_ARB_TIMEOUT_EN
  ,
  output logic                    abort
`endif
);

  if (SEL_W != $clog2(N_SRC) || N_SRC < 2 || N_SRC > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("scale_fifo_rd_arbiter: inconsistent parameters");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [SEL_W-1:0]  rr_ptr;
  logic              in_burst;
  logic              beat;
  logic              grant_hit;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  next_ptr;
  logic [DATA_W-1:0] src_word [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_word
    assign src_word[i] = src_data[i*DATA_W +: DATA_W];
  end

  // First requester at or after rr_ptr, wrapping at N_SRC.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = rr_ptr;
    for (int k = 0; k < N_SRC; k++) begin
      if (!grant_hit && src_vld[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
      cand = (cand == SEL_W'(N_SRC-1)) ? '0 : cand + SEL_W'(1);
    end
  end

  assign in_burst = (state == BURST);
  assign out_vld  = in_burst & src_vld[out_sel];
  assign out_data = in_burst ? src_word[out_sel] : '0;
  assign out_last = in_burst & (beat_cnt == len_q - LEN_W'(1));
  assign beat     = out_vld & out_rdy;
  assign next_ptr = (out_sel == SEL_W'(N_SRC-1)) ? '0 : out_sel + SEL_W'(1);

  always_comb begin
    src_en = '0;
    if (in_burst) src_en[out_sel] = out_rdy;
  end

`ifdef SCALE_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= IDLE;
      out_sel    <= '0;
      len_q      <= LEN_W'(1);
      beat_cnt   <= '0;
      rr_ptr     <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
`ifdef SCALE_ARB_TIMEOUT_EN
      stall_cnt  <= '0;
      abort      <= 1'b0;
`endif
    end else begin
      burst_done <= 1'b0;
`ifdef SCALE_ARB_TIMEOUT_EN
      abort      <= 1'b0;
`endif
      if (state == IDLE) begin
        if (arb_en && grant_hit) begin
          state    <= BURST;
          out_sel  <= grant_idx;
          len_q    <= (burst_len == '0) ? LEN_W'(1) : burst_len;
          beat_cnt <= '0;
          busy     <= 1'b1;
`ifdef SCALE_ARB_TIMEOUT_EN
          stall_cnt <= '0;
`endif
        end
      end else begin
        if (beat) begin
          beat_cnt <= beat_cnt + LEN_W'(1);
`ifdef SCALE_ARB_TIMEOUT_EN
          stall_cnt <= '0;
`endif
          if (out_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            burst_done <= 1'b1;
            rr_ptr     <= next_ptr;
          end
        end
`ifdef SCALE_ARB_TIMEOUT_EN
        // The TIMEOUT-th consecutive empty cycle ends the burst without a last beat.
        else if (!src_vld[out_sel]) begin
          if (stall_cnt == STALL_W'(TIMEOUT-1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            burst_done <= 1'b1;
            abort      <= 1'b1;
            rr_ptr     <= next_ptr;
            stall_cnt  <= '0;
          end else begin
            stall_cnt  <= stall_cnt + STALL_W'(1);
          end
        end
`endif
      end
    end
  end

endmodule
